// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: shared FSM state encoding and default constants for the debouncer
package input_debouncer_pkg;
    typedef enum logic [1:0] {S_LOW, S_WAIT_H, S_HIGH, S_WAIT_L} state_t;
    localparam int DEBOUNCE_CYCLES_DEF = 1000;
    localparam int GLITCH_MAX = 255;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop metastability synchronizer, reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, s1} <= 2'b00;
        else     {q, s1} <= {s1, d};
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: qualifies a bouncy level over DEBOUNCE_CYCLES synchronized samples
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_raw,
    output logic       level,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] glitch_cnt
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic in_s, rise_nx, fall_nx, abort;
    sync_2ff u_sync (.clk(clk), .rst(rst), .d(in_raw), .q(in_s));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= S_LOW;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            glitch_cnt <= 8'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            level      <= rise_nx ? 1'b1 : fall_nx ? 1'b0 : level;
            rise_pulse <= rise_nx;
            fall_pulse <= fall_nx;
            glitch_cnt <= (abort && glitch_cnt != 8'(GLITCH_MAX)) ? glitch_cnt + 8'd1 : glitch_cnt;
        end
    // cnt defaults to 0 so it rests at 0 whenever the FSM is outside a WAIT state
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        abort    = 1'b0;
        case (state)
            S_LOW:    state_nx = in_s ? S_WAIT_H : S_LOW;
            S_WAIT_H: if (!in_s) begin
                          state_nx = S_LOW;
                          abort    = 1'b1;
                      end else if (cnt == CNT_LAST) begin
                          state_nx = S_HIGH;
                          rise_nx  = 1'b1;
                      end else cnt_nx = cnt + 1'b1;
            S_HIGH:   state_nx = in_s ? S_HIGH : S_WAIT_L;
            S_WAIT_L: if (in_s) begin
                          state_nx = S_HIGH;
                          abort    = 1'b1;
                      end else if (cnt == CNT_LAST) begin
                          state_nx = S_LOW;
                          fall_nx  = 1'b1;
                      end else cnt_nx = cnt + 1'b1;
            default:  state_nx = S_LOW;
        endcase
    end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed vectors plus a bounded random bounce run against a run-length model
module tb_input_debouncer;
    localparam int D = 4;
    logic clk = 1'b0, rst = 1'b1, in_raw = 1'b0;
    logic level, rise_pulse, fall_pulse;
    logic [7:0] glitch_cnt;
    int n_vec = 0, n_err = 0, n_rise = 0;

    input_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_raw(in_raw), .level(level),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rise_pulse) n_rise <= n_rise + 1;

    // level flips once in_s has disagreed with it for D+1 consecutive samples; a broken run is a glitch
    logic m1, m2, m_level, m_rise, m_fall;
    logic [7:0] m_glitch;
    int run;
    always @(posedge clk or posedge rst)
        if (rst) begin
            m1 <= 0; m2 <= 0; m_level <= 0; m_rise <= 0; m_fall <= 0; m_glitch <= 0; run <= 0;
        end else begin
            m1 <= in_raw;
            m2 <= m1;
            m_rise <= 0;
            m_fall <= 0;
            if (m2 != m_level) begin
                if (run == D) begin
                    m_level <= m2; m_rise <= m2; m_fall <= !m2; run <= 0;
                end else run <= run + 1;
            end else begin
                if (run != 0 && m_glitch != 8'd255) m_glitch <= m_glitch + 8'd1;
                run <= 0;
            end
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base, seg, last;
        logic p_rise, p_fall, p_level;
        repeat (2) tick();
        check("rst_level", level, 0);
        check("rst_rise", rise_pulse, 0);
        check("rst_fall", fall_pulse, 0);
        check("rst_glitch", glitch_cnt, 0);
        rst = 1'b0;
        in_raw = 1'b1;
        repeat (6) tick();
        check("rise_e6_level", level, 0);
        check("rise_e6_pulse", rise_pulse, 0);
        tick();
        check("rise_e7_level", level, 1);
        check("rise_e7_pulse", rise_pulse, 1);
        check("rise_glitch", glitch_cnt, 0);
        tick();
        check("rise_e8_pulse", rise_pulse, 0);
        check("rise_e8_level", level, 1);
        in_raw = 1'b0;
        repeat (6) tick();
        check("fall_e6_level", level, 1);
        check("fall_e6_pulse", fall_pulse, 0);
        tick();
        check("fall_e7_pulse", fall_pulse, 1);
        check("fall_e7_level", level, 0);
        tick();
        check("fall_e8_pulse", fall_pulse, 0);
        base = n_rise;
        in_raw = 1'b1;
        repeat (2) tick();
        in_raw = 1'b0;
        repeat (6) tick();
        check("glitch_level", level, 0);
        check("glitch_cnt1", glitch_cnt, 1);
        check("glitch_norise", n_rise - base, 0);
        base = n_rise;
        repeat (300) begin
            in_raw = 1'b1;
            tick();
            in_raw = 1'b0;
            repeat (5) tick();
        end
        check("burst_level", level, 0);
        check("burst_sat", glitch_cnt, 255);
        check("burst_norise", n_rise - base, 0);
        base = n_rise;
        in_raw = 1'b1;
        repeat (5) tick();
        #1 rst = 1'b1;
        #1;
        check("arst_level", level, 0);
        check("arst_rise", rise_pulse, 0);
        check("arst_fall", fall_pulse, 0);
        check("arst_glitch", glitch_cnt, 0);
        #2 rst = 1'b0;
        repeat (6) tick();
        check("rel_e6_level", level, 0);
        check("rel_e6_pulse", rise_pulse, 0);
        tick();
        check("rel_e7_pulse", rise_pulse, 1);
        check("rel_e7_level", level, 1);
        tick();
        check("rel_e8_pulse", rise_pulse, 0);
        check("rel_glitch", glitch_cnt, 0);
        check("rel_one_rise", n_rise - base, 1);
        last = level ? 1 : 2;
        p_rise = rise_pulse;
        p_fall = fall_pulse;
        p_level = level;
        seg = 0;
        for (int i = 0; i < 10000; i++) begin
            if (seg == 0) begin
                in_raw = ~in_raw;
                seg = $urandom_range(1, 9);
            end
            seg--;
            tick();
            check("rnd_level", level, m_level);
            check("rnd_rise", rise_pulse, m_rise);
            check("rnd_fall", fall_pulse, m_fall);
            check("rnd_glitch", glitch_cnt, m_glitch);
            check("rnd_excl", rise_pulse & fall_pulse, 0);
            check("rnd_rise_1cyc", rise_pulse & p_rise, 0);
            check("rnd_fall_1cyc", fall_pulse & p_fall, 0);
            check("rnd_toggle", level ^ p_level, rise_pulse | fall_pulse);
            if (rise_pulse) begin
                check("rnd_alt_rise", last, 2);
                last = 1;
            end
            if (fall_pulse) begin
                check("rnd_alt_fall", last, 1);
                last = 2;
            end
            p_rise = rise_pulse;
            p_fall = fall_pulse;
            p_level = level;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000, meaning the number of consecutive synchronized samples that qualify a level change (legal range 2..65535).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the debounce counter width (must hold DEBOUNCE_CYCLES-1).
REQ-003 The block SHALL have port clk, input, 1, meaning the system clock; all state is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning the reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_raw, input, 1, meaning the asynchronous, bouncy external level (button or switch).
REQ-006 The block SHALL have port level, output, 1, meaning the debounced level, registered.
REQ-007 The block SHALL have port rise_pulse, output, 1, meaning a one-cycle strobe on a qualified 0->1 change; it feeds the downstream pulse-stretching stage.
REQ-008 The block SHALL have port fall_pulse, output, 1, meaning a one-cycle strobe on a qualified 1->0 change.
REQ-009 The block SHALL have port glitch_cnt, output, 8, meaning the saturating count of rejected (aborted) transitions.

Function
REQ-010 in_raw SHALL pass through a two-flop synchronizer; its second-stage output is in_s, and no logic other than the first flop SHALL sample in_raw.
REQ-011 The FSM SHALL have states S_LOW, S_WAIT_H, S_HIGH and S_WAIT_L.
REQ-012 In S_LOW: level=0; if in_s=1 the FSM SHALL go to S_WAIT_H with cnt cleared to 0.
REQ-013 In S_WAIT_H, if in_s=1 and cnt=DEBOUNCE_CYCLES-1, the FSM SHALL go to S_HIGH, set level=1 and assert rise_pulse for exactly the next cycle.
REQ-014 In S_WAIT_H, if in_s=1 and cnt<DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-015 In S_WAIT_H, if in_s=0, the FSM SHALL return to S_LOW, increment glitch_cnt, and emit no pulse.
REQ-016 S_HIGH and S_WAIT_L SHALL mirror REQ-012..015 with the polarity inverted: the commit clears level and asserts fall_pulse for one cycle.
REQ-017 level SHALL change only on a committed transition, and level SHALL hold its value throughout the WAIT states.
REQ-018 Latency: for in_raw stable-high set up before clk edge 1, level and rise_pulse SHALL be high after edge DEBOUNCE_CYCLES+3; fall has the same latency.
REQ-019 rise_pulse and fall_pulse SHALL be mutually exclusive, SHALL never be asserted for two consecutive cycles, and SHALL be registered with no combinational path from in_raw.
REQ-020 The minimum spacing between a rise_pulse and the following fall_pulse SHALL be DEBOUNCE_CYCLES+1 cycles.
REQ-021 glitch_cnt SHALL saturate at 255 with no wrap; saturation SHALL NOT affect FSM behaviour.
REQ-022 cnt SHALL never exceed DEBOUNCE_CYCLES-1, and cnt SHALL be don't-care outside the WAIT states; the implementation SHALL hold cnt at 0 outside the WAIT states.

Reset
REQ-023 On rst=1, immediately and independent of clk: synchronizer flops SHALL be 0; state SHALL be S_LOW; cnt SHALL be 0; level, rise_pulse and fall_pulse SHALL be 0; glitch_cnt SHALL be 0.
REQ-024 Reset during a WAIT state SHALL abort the qualification with no pulse and no glitch count.
REQ-025 If in_raw is high when rst deasserts, the block SHALL qualify it normally and emit one rise_pulse after the REQ-018 latency, counted from the first edge after deassertion.

Structure
REQ-026 Package input_debouncer_pkg SHALL hold the FSM state enum (2 bits) and the default constants DEBOUNCE_CYCLES_DEF=1000 and GLITCH_MAX=255.
REQ-027 The synchronizer SHALL be a separate sub-module sync_2ff (clk, rst, d, q), reset to 0, reusable by other blocks.
REQ-028 The top level SHALL contain only the FSM, cnt, output registers and glitch counter.

Verification (bench DEBOUNCE_CYCLES=4)
REQ-029 The bench SHALL cover: in_raw 0->1 held before edge 1 -> level=1 and rise_pulse=1 for one cycle after edge 7; glitch_cnt=0.
REQ-030 The bench SHALL cover: in_raw high for 2 cycles then low -> level stays 0, no rise_pulse, glitch_cnt=1.
REQ-031 The bench SHALL cover: from level=1, in_raw low held -> fall_pulse one cycle after edge 7 relative to the change; level=0.
REQ-032 The bench SHALL cover: 300 one-cycle-high bursts, each separated by 5 low cycles -> level stays 0, glitch_cnt=255 (saturated).
REQ-033 The bench SHALL cover: rst asserted mid-S_WAIT_H (cnt=2) -> all outputs 0 asynchronously, no pulse; with in_raw held high, one rise_pulse 7 edges after release.
REQ-034 The bench SHALL cover: random bouncy stimulus (10k cycles) -> assertions hold that pulses are one cycle, mutually exclusive, and alternate rise/fall, and level toggles only with a pulse.
